mul_core: RTL and testbench
===========================

// Module: mul_core
// PURPOSE
//  Calculation core directly downstream of the parameter loader. Captures signed operands a0/a1
//  on a rising edge of start_calc, forms a0*a1 with an iterative shift-add multiplier
//  (one bit per cycle), saturates the product to WIDTH bits and presents it with a one-cycle
//  valid strobe. Drives core_busy back to the loader so no new operand pair is launched mid-calc.
// PARAMETERS
//  WIDTH  32  operand and result width (signed); product accumulator is 2*WIDTH bits
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  a0            in   WIDTH  signed operand A; sampled only on start edge
//  a1            in   WIDTH  signed operand B; sampled only on start edge
//  start_calc    in   1      level from loader; rising edge starts a calculation
//  core_busy     out  1      high while a calculation is in flight
//  result        out  WIDTH  signed saturated product; holds until next completion
//  result_valid  out  1      one-cycle strobe: result/overflow updated this cycle
//  overflow      out  1      product exceeded signed WIDTH range, result saturated; held with result
// BEHAVIOUR
//  Reset (async, any state): state=S_IDLE; core_busy=0, result=0, result_valid=0, overflow=0;
//   start edge register, operand/accumulator registers and bit counter cleared.
//  Start detect: start_q <= start_calc every cycle in every state; start_pulse = start_calc & ~start_q.
//   Only start_pulse in S_IDLE is acted on. Pulses in other states are dropped, not queued.
//   A level still high on return to S_IDLE does not retrigger. start_calc must go low, then high again.
//  FSM (core_busy = state != S_IDLE, registered):
//   S_IDLE: on start_pulse latch mag_a=|a0|, mag_b=|a1| (WIDTH-bit unsigned; |-2^(W-1)| = 2^(W-1)),
//     neg = a0[W-1]^a1[W-1], acc=0, cnt=0; -> S_MUL.
//   S_MUL: if mag_b[0] acc += mag_a << cnt; mag_b >>= 1; cnt++; after WIDTH cycles (cnt==WIDTH-1
//     processed) -> S_FIX. No early exit on mag_b==0; latency is fixed.
//   S_FIX: apply sign: p = neg ? -acc : acc (2*WIDTH signed). A zero product is always +0.
//     If p > 2^(W-1)-1 then result=0x7FFF_FFFF, overflow=1. If p < -2^(W-1) then
//     result=0x8000_0000, overflow=1. Otherwise result=p[W-1:0], overflow=0. -> S_DONE.
//   S_DONE: result_valid=1 for this cycle only; -> S_IDLE (core_busy low next cycle).
//  Latency: start_pulse seen in cycle N -> core_busy=1 from N+1. result_valid=1 in cycle N+WIDTH+2.
//   core_busy=0 from N+WIDTH+3. Earliest next start_pulse is acted on in N+WIDTH+3.
//  Loader interplay: the loader's start_calc is a ~2-cycle pulse and its operands are zero-extended
//   8-bit values. The core nevertheless supports the full signed range.
//  result/overflow change only in S_FIX (visible in S_DONE). Otherwise they are stable, including while busy.
//  Illegal state encoding -> S_IDLE with core_busy=0, outputs unchanged.
// STRUCTURE
//  watchdog_pkg: typedef enum logic [1:0] {S_IDLE,S_MUL,S_FIX,S_DONE} mul_state_t;
//   localparams CORE_W=32, SAT_MAX=32'h7FFF_FFFF, SAT_MIN=32'h8000_0000.
//  Single module. The sign-apply/saturate logic in S_FIX is the one natural sub-module:
//   sat_fix (combinational; in: acc[2W-1:0], neg; out: result[W-1:0], overflow).
//  Counter width $clog2(WIDTH).
// TESTING
//  1 a0=3, a1=5, start 0->1 for 2 cycles -> busy 1 cycle later; 34 cycles later valid=1,
//    result=15, ovf=0; busy drops the next cycle.
//  2 a0=-7, a1=6 -> result=-42 (0xFFFF_FFD6), ovf=0. a0=0, a1=-9 -> result=0, ovf=0.
//  3 a0=0x0001_0000, a1=0x0001_0000 -> result=0x7FFF_FFFF, ovf=1. a0=-65536, a1=65536 ->
//    result=0x8000_0000, ovf=1. a0=-2^31, a1=1 -> 0x8000_0000, ovf=0.
//  4 Hold start_calc high across whole calc; then pulse it again during busy -> exactly one valid strobe.
//    Drop low then raise -> second calc runs.
//  5 Change a0/a1 every cycle while busy -> result reflects operands at the start edge only.
//  6 Assert rst_n=0 mid S_MUL (cnt=10) -> immediately busy=0, result=0, ovf=0, valid=0.
//    Release and start 255*255 -> 65025.

Source files
------------

// File: rtl/mul_core_pkg.sv
// Shared types and constants for the signed shift-add multiply core.
package mul_core_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIX,
        S_DONE
    } mul_state_t;

    localparam int CORE_W = 32;
    localparam logic [CORE_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [CORE_W-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mul_core_sat_fix.sv
// Applies the product sign to the unsigned magnitude and saturates to WIDTH bits.
module sat_fix
    import mul_core_pkg::*;
#(
    parameter int WIDTH = CORE_W
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               neg,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     top;
    logic               pos_ovf;
    logic               neg_ovf;

    // Negating a zero magnitude yields zero, so -0 never escapes.
    assign prod = neg ? (~acc + 1'b1) : acc;

    // In range only when the upper W+1 bits are a pure sign extension.
    assign top     = prod[2*WIDTH-1:WIDTH-1];
    assign pos_ovf = ~prod[2*WIDTH-1] & (|top);
    assign neg_ovf = prod[2*WIDTH-1] & ~(&top);

    always_comb begin
        result   = prod[WIDTH-1:0];
        overflow = 1'b0;
        if (pos_ovf) begin
            result   = {1'b0, {(WIDTH-1){1'b1}}};
            overflow = 1'b1;
        end else if (neg_ovf) begin
            result   = {1'b1, {(WIDTH-1){1'b0}}};
            overflow = 1'b1;
        end
    end

endmodule

// File: rtl/mul_core.sv
// Iterative signed multiplier: one partial product per cycle, saturated result.
module mul_core
    import mul_core_pkg::*;
#(
    parameter int WIDTH = CORE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             start_calc,
    output logic             core_busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mul_state_t state;
    mul_state_t state_nxt;

    logic               start_q;
    logic               start_pulse;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   fix_result;
    logic               fix_ovf;

    assign start_pulse = start_calc & ~start_q;
    assign core_busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_pulse) state_nxt = S_MUL;
            S_MUL:   if (cnt == LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    sat_fix #(
        .WIDTH(WIDTH)
    ) u_sat_fix (
        .acc(acc),
        .neg(neg),
        .result(fix_result),
        .overflow(fix_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            mag_a        <= '0;
            mag_b        <= '0;
            neg          <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            result       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            start_q      <= start_calc;
            result_valid <= (state == S_FIX);
            unique case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        // |-2^(W-1)| fits because magnitudes are unsigned.
                        mag_a <= a0[WIDTH-1] ? (~a0 + 1'b1) : a0;
                        mag_b <= a1[WIDTH-1] ? (~a1 + 1'b1) : a1;
                        neg   <= a0[WIDTH-1] ^ a1[WIDTH-1];
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                S_MUL: begin
                    if (mag_b[0]) begin
                        acc <= acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
                    end
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                end
                S_FIX: begin
                    result   <= fix_result;
                    overflow <= fix_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_core.sv
// Self-checking bench for mul_core against a 64-bit arithmetic reference.
module tb_mul_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        start_calc;
    logic        core_busy;
    logic [31:0] result;
    logic        result_valid;
    logic        overflow;

    int checks;
    int fails;

    mul_core #(
        .WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a0(a0),
        .a1(a1),
        .start_calc(start_calc),
        .core_busy(core_busy),
        .result(result),
        .result_valid(result_valid),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] model(input logic [31:0] x,
                                          input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        if (p > 64'sd2147483647)
            return {1'b1, 32'h7FFF_FFFF};
        if (p < -64'sd2147483648)
            return {1'b1, 32'h8000_0000};
        return {1'b0, p[31:0]};
    endfunction

    // Launches one calculation from a negedge; returns the strobe data,
    // the number of edges until the strobe, busy seen after edge 1,
    // and busy one cycle after the strobe.
    task automatic do_calc(input logic [31:0] x, input logic [31:0] y,
                           input bit scramble,
                           output logic [31:0] r, output logic o,
                           output int lat, output logic b1,
                           output logic b_after);
        a0 = x;
        a1 = y;
        start_calc = 1'b1;
        lat = 0;
        r = 'x;
        o = 1'bx;
        b1 = 1'bx;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) b1 = core_busy;
            if (k == 2) start_calc = 1'b0;
            if (scramble) begin
                a0 = $urandom;
                a1 = $urandom;
            end
            if (result_valid) begin
                lat = k;
                r = result;
                o = overflow;
                break;
            end
        end
        start_calc = 1'b0;
        @(negedge clk);
        b_after = core_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_calc = 1'b0;
        a0 = '0;
        a1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({core_busy, result_valid, overflow, result} !== 35'd0) begin
            $display("FAIL reset: got busy=%b valid=%b ovf=%b res=%h want all 0",
                     core_busy, result_valid, overflow, result);
            fails++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [31:0] r;
        logic o, b1, ba;
        int lat;
        do_calc(32'd3, 32'd5, 1'b0, r, o, lat, b1, ba);
        checks++;
        if (b1 !== 1'b1) begin
            $display("FAIL busy_rise: got %b want 1", b1);
            fails++;
        end
        checks++;
        if (lat !== 34) begin
            $display("FAIL latency: got %0d want 34", lat);
            fails++;
        end
        checks++;
        if ({o, r} !== {1'b0, 32'd15}) begin
            $display("FAIL 3x5: got ovf=%b res=%h want ovf=0 res=0000000f", o, r);
            fails++;
        end
        checks++;
        if (ba !== 1'b0) begin
            $display("FAIL busy_drop: got %b want 0", ba);
            fails++;
        end
    endtask

    task automatic test_directed();
        logic [31:0] xs [6];
        logic [31:0] ys [6];
        logic [32:0] want [6];
        logic [31:0] r;
        logic o, b1, ba;
        int lat;
        xs = '{-32'sd7, 32'd0, 32'h0001_0000, -32'sd65536, 32'h8000_0000, 32'h8000_0000};
        ys = '{32'd6, -32'sd9, 32'h0001_0000, 32'd65536, 32'd1, 32'hFFFF_FFFF};
        want = '{{1'b0, 32'hFFFF_FFD6}, {1'b0, 32'h0}, {1'b1, 32'h7FFF_FFFF},
                 {1'b1, 32'h8000_0000}, {1'b0, 32'h8000_0000}, {1'b1, 32'h7FFF_FFFF}};
        for (int i = 0; i < 6; i++) begin
            do_calc(xs[i], ys[i], 1'b0, r, o, lat, b1, ba);
            checks++;
            if ({o, r} !== want[i]) begin
                $display("FAIL directed[%0d] %h*%h: got ovf=%b res=%h want ovf=%b res=%h",
                         i, xs[i], ys[i], o, r, want[i][32], want[i][31:0]);
                fails++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, r;
        logic [32:0] w;
        logic o, b1, ba;
        int lat;
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 2 == 0) x = 32'($signed(x[17:0]));
            if (i % 4 == 0) y = 32'($signed(y[12:0]));
            w = model(x, y);
            do_calc(x, y, 1'b0, r, o, lat, b1, ba);
            checks++;
            if ({o, r} !== w || lat != 34) begin
                $display("FAIL random[%0d] %h*%h: got ovf=%b res=%h lat=%0d want ovf=%b res=%h lat=34",
                         i, x, y, o, r, lat, w[32], w[31:0]);
                fails++;
            end
        end
    endtask

    task automatic test_operand_change();
        logic [31:0] x, y, r;
        logic [32:0] w;
        logic o, b1, ba;
        int lat;
        for (int i = 0; i < 3; i++) begin
            x = 32'($signed(12'($urandom)));
            y = 32'($signed(14'($urandom)));
            w = model(x, y);
            do_calc(x, y, 1'b1, r, o, lat, b1, ba);
            checks++;
            if ({o, r} !== w) begin
                $display("FAIL operand_hold[%0d]: got ovf=%b res=%h want ovf=%b res=%h",
                         i, o, r, w[32], w[31:0]);
                fails++;
            end
        end
    endtask

    task automatic test_start_hold();
        int strobes;
        logic [31:0] kept;
        a0 = 32'd11;
        a1 = 32'd13;
        start_calc = 1'b1;
        strobes = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (result_valid) strobes++;
        end
        checks++;
        if (strobes !== 1 || result !== 32'd143) begin
            $display("FAIL start_held: got strobes=%0d res=%h want 1 and 0000008f",
                     strobes, result);
            fails++;
        end
        start_calc = 1'b0;
        @(negedge clk);
        a0 = -32'sd4;
        a1 = 32'd25;
        start_calc = 1'b1;
        strobes = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 2) start_calc = 1'b0;
            if (k == 10) begin
                a0 = 32'd1000;
                a1 = 32'd1000;
                start_calc = 1'b1;
            end
            if (k == 12) start_calc = 1'b0;
            if (result_valid) strobes++;
        end
        kept = result;
        checks++;
        if (strobes !== 1 || kept !== 32'hFFFF_FF9C || core_busy !== 1'b0) begin
            $display("FAIL pulse_in_busy: got strobes=%0d res=%h busy=%b want 1 ffffff9c 0",
                     strobes, kept, core_busy);
            fails++;
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] r;
        logic o, b1, ba;
        int lat;
        a0 = 32'h0001_0000;
        a1 = 32'h0001_0000;
        start_calc = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2) start_calc = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({core_busy, result_valid, overflow, result} !== 35'd0) begin
            $display("FAIL mid_reset: got busy=%b valid=%b ovf=%b res=%h want all 0",
                     core_busy, result_valid, overflow, result);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_calc(32'd255, 32'd255, 1'b0, r, o, lat, b1, ba);
        checks++;
        if ({o, r} !== {1'b0, 32'd65025} || lat != 34) begin
            $display("FAIL after_reset: got ovf=%b res=%h lat=%0d want 0 0000fe01 34",
                     o, r, lat);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        logic o1, o2, b1, ba;
        int lat;
        do_calc(32'd200, 32'd17, 1'b0, r1, o1, lat, b1, ba);
        do_calc(-32'sd3, -32'sd3, 1'b0, r2, o2, lat, b1, ba);
        checks++;
        if ({o1, r1, o2, r2} !== {1'b0, 32'd3400, 1'b0, 32'd9}) begin
            $display("FAIL back_to_back: got %h/%h want 00000d48/00000009", r1, r2);
            fails++;
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        test_reset();
        test_latency();
        test_directed();
        test_random();
        test_operand_change();
        test_start_hold();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
